// File: rtl/mm_r2mm_radix2_if.sv
// mm_r2mm_radix2_if
// Operand/result bundle for the bit-serial Montgomery multiplier.
//   x, y, m : K-bit operands (x < m, y < m, m odd and >= 3)
//   req     : start pulse, only honoured while the engine is idle
//   res     : K-bit result x*y*2^(-K) mod m, held until the next completion
//   val     : one-cycle pulse marking a new res
// Handshake: req is a request strobe with no ready; a req sampled in IDLE
// latches x/y/m and starts an operation, a req seen while busy is dropped.
// val has no back-pressure: the consumer takes res on or after the val cycle.
interface mm_r2mm_radix2_if #(
    parameter int K = 256
);
    logic [K-1:0] x;
    logic [K-1:0] y;
    logic [K-1:0] m;
    logic         req;
    logic [K-1:0] res;
    logic         val;

    modport master (
        output x, y, m, req,
        input  res, val
    );

    modport slave (
        input  x, y, m, req,
        output res, val
    );
endinterface

// File: rtl/mm_r2mm_radix2.sv
// mm_r2mm_radix2
// Bit-serial radix-2 Montgomery modular multiplier: res = x*y*2^(-K) mod m,
// consuming one bit of x per clock. Fixed latency of K+1 cycles from the
// req-sampling edge to val, one result every K+2 cycles with req held high.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset
//   bus     : slave side of mm_r2mm_radix2_if (x, y, m, req, res, val)
//   state_o : current FSM state, for observation only
module mm_r2mm_radix2 #(
    parameter int K = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mm_r2mm_radix2_if.slave      bus,
    output logic [1:0]           state_o
);
    localparam int CNT_W = $clog2(K) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SUB  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [K-1:0]     xs_q, xs_d;
    logic [K-1:0]     ys_q, ys_d;
    logic [K-1:0]     ms_q, ms_d;
    logic [K+1:0]     s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [K-1:0]     res_q, res_d;
    logic             val_q, val_d;

    // Step sum and final-subtraction helpers.
    logic [K+1:0]     t;
    logic [K-1:0]     diff;
    logic             s_ge_m;

    // The final subtraction only needs the low K bits of S - m: when S >= m
    // the in-contract result is below m and therefore fits in K bits.
    assign diff    = s_q[K-1:0] - ms_q;
    assign s_ge_m  = (s_q >= {2'b00, ms_q});
    assign state_o = state_q;
    assign bus.res = res_q;
    assign bus.val = val_q;

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        ms_d    = ms_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        val_d   = 1'b0;
        t       = '0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    xs_d    = bus.x;
                    ys_d    = bus.y;
                    ms_d    = bus.m;
                    s_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                t = s_q + (xs_q[0] ? {2'b00, ys_q} : {(K+2){1'b0}});
                // Adding the odd modulus makes the sum even so the halving
                // below is exact modulo m.
                if (t[0]) begin
                    t = t + {2'b00, ms_q};
                end
                s_d   = t >> 1;
                xs_d  = xs_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(K - 1)) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                res_d   = s_ge_m ? diff : s_q[K-1:0];
                val_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            ms_q    <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            ms_q    <= ms_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            val_q   <= val_d;
        end
    end
endmodule

// File: tb/tb_mm_r2mm_radix2.sv
// tb_mm_r2mm_radix2
// Directed bench for mm_r2mm_radix2 at K = 8. Expected results are
// hand-computed: for m = 13, R = 256, R mod 13 = 9 and R^-1 mod 13 = 3, so
// res = 3*x*y mod 13; for m = 255 and m = 3, R mod m = 1 so res = x*y mod m.
module tb_mm_r2mm_radix2;
    localparam int K = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    mm_r2mm_radix2_if #(.K(K)) bus ();

    mm_r2mm_radix2 #(.K(K)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives operands with a one-cycle req pulse; returns #1 after edge E0.
    task automatic launch(input int xv, input int yv, input int mv);
        @(negedge clk);
        bus.x   = K'(xv);
        bus.y   = K'(yv);
        bus.m   = K'(mv);
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    // Watches a bounded number of cycles, sampling #1 after each edge.
    // first is the edge index (1-based) of the first val, -1 if none.
    task automatic watch(input int cycles, output int first, output int pulses,
                         output int r);
        first  = -1;
        pulses = 0;
        r      = -1;
        for (int i = 1; i <= cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.val === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    r     = int'(bus.res);
                end
            end
        end
    endtask

    task automatic run_vec(input string tag, input int xv, input int yv,
                           input int mv, input int exp_res);
        int first, pulses, r;
        launch(xv, yv, mv);
        watch(12, first, pulses, r);
        check({tag, "_lat"}, first, K + 1);
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_res"}, r, exp_res);
    endtask

    initial begin
        int first, pulses, r;

        bus.x   = '0;
        bus.y   = '0;
        bus.m   = '0;
        bus.req = 1'b0;
        rst_n   = 1'b0;

        // Reset for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", int'(bus.res), 0);
        check("rst_val", int'(bus.val), 0);
        check("rst_state", int'(dbg_state), 0);
        rst_n = 1'b1;

        // Idle with req low: no val for 50 cycles.
        watch(50, first, pulses, r);
        check("idle_no_val", pulses, 0);

        // Basic vectors, m = 13.
        run_vec("m13_5x7", 5, 7, 13, 1);
        run_vec("m13_one_x7", 9, 7, 13, 7);
        run_vec("m13_12x12", 12, 12, 13, 3);
        run_vec("m13_0x12", 0, 12, 13, 0);
        run_vec("m13_1x1", 1, 1, 13, 3);
        run_vec("m13_2x3", 2, 3, 13, 5);
        // Wide modulus exercising the K+2-bit accumulator.
        run_vec("m255_200x100", 200, 100, 255, 110);
        run_vec("m255_254x254", 254, 254, 255, 1);
        // Smallest legal modulus.
        run_vec("m3_2x2", 2, 2, 3, 1);

        // req re-asserted 3 cycles into an operation is ignored.
        launch(5, 7, 13);
        repeat (2) @(posedge clk);
        #1;
        bus.x   = 8'd12;
        bus.y   = 8'd12;
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        watch(20, first, pulses, r);
        check("midreq_lat", first, K + 1 - 3);
        check("midreq_pulses", pulses, 1);
        check("midreq_res", r, 1);

        // Reset mid-CALC aborts: no val, res cleared, FSM idle.
        launch(12, 12, 13);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_busy", int'(dbg_state), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_res", int'(bus.res), 0);
        check("midrst_state", int'(dbg_state), 0);
        watch(20, first, pulses, r);
        check("midrst_no_val", pulses, 0);
        run_vec("post_rst_5x7", 5, 7, 13, 1);

        // Operands change right after latching: result uses latched values.
        launch(12, 12, 13);
        bus.x = 8'd1;
        bus.y = 8'd1;
        watch(12, first, pulses, r);
        check("latch_lat", first, K + 1);
        check("latch_res", r, 3);

        // Out-of-contract even modulus: latency unchanged, res not checked.
        launch(5, 7, 12);
        watch(12, first, pulses, r);
        check("evenm_lat", first, K + 1);
        check("evenm_pulses", pulses, 1);

        // Back-to-back with req held high: next op re-latches current inputs.
        @(negedge clk);
        bus.x   = 8'd5;
        bus.y   = 8'd7;
        bus.m   = 8'd13;
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.x = 8'd9;
        watch(K + 1, first, pulses, r);
        check("b2b0_lat", first, K + 1);
        check("b2b0_res", r, 1);
        // Next IDLE edge starts operation two, K+2 cycles after the first.
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        check("b2b_val_low", int'(bus.val), 0);
        check("b2b_restart", int'(dbg_state), 1);
        watch(12, first, pulses, r);
        check("b2b1_lat", first, K + 1);
        check("b2b1_pulses", pulses, 1);
        check("b2b1_res", r, 7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
